alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, request accepted this cycle when high with in_valid.
REQ-008 SHALL have port op, input, 6, operation code.
REQ-009 SHALL have ports a and b, input, WIDTH, operands.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port result, output, WIDTH, registered result.
REQ-013 SHALL have port cmp_true, output, 1, high when a comparison op's result is 1.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL keep base op codes: ADD 0, SUB 1, AND 2, XOR 3, OR 4, SLL 5, SRL 6, SRA 7, EQ 8, GEU 9, LTU 10, NE 11, GTU 12, LT 13, GE 14, PASSB 63.
REQ-016 SHALL add M ops: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
REQ-017 SHALL give result 0 and cmp_true 0 for any other op code.
REQ-018 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH; comparisons yield zero-extended 0/1.
REQ-019 SHALL use FSM IDLE, CALC, FIN, DONE; in_ready = (state==IDLE).
REQ-020 SHALL move IDLE->DONE on acceptance of a base op, with the result captured at that edge (latency 1).
REQ-021 SHALL move IDLE->CALC on acceptance of an M op, latching operand magnitudes and sign flags.
REQ-022 SHALL process one bit per cycle in CALC (shift-add multiply, restoring divide) for exactly WIDTH cycles, then go to FIN.
REQ-023 SHALL apply sign correction in FIN, then go to DONE; M-op latency from accept edge to out_valid is WIDTH+2 cycles.
REQ-024 SHALL hold out_valid=1 in DONE with result and cmp_true stable until out_ready=1, then go to IDLE.
REQ-025 SHALL accept no new request in the same cycle as the DONE->IDLE handoff.
REQ-026 SHALL treat divide by zero as: DIV/DIVU quotient all ones; REM/REMU remainder = a.
REQ-027 SHALL treat signed overflow (most-negative / -1) as: DIV gives most-negative; REM gives 0.
REQ-028 SHALL ignore in_valid, op, a and b while busy.

Reset
REQ-029 SHALL on rst force state IDLE, result 0, cmp_true 0, out_valid 0, busy 0, and clear all iteration registers.
REQ-030 SHALL abort any in-flight M op when rst is asserted mid-operation, with no result delivered.
REQ-031 SHALL have in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL put op-code constants, the state enum and the WIDTH legality check in shared package alu_pkg.
REQ-033 SHALL instantiate one sub-module, alu_muldiv_core, holding the iteration counter, accumulator/remainder and sign-fix logic.

Verification
REQ-034 SHALL test: WIDTH=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid next cycle, result 0x00000000.
REQ-035 SHALL test: SRA a=0x80000000 b=0x24 -> result 0xF8000000 (shift 4).
REQ-036 SHALL test: MULH a=-2 b=3 -> result 0xFFFFFFFF; out_valid exactly 34 cycles after accept.
REQ-037 SHALL test: DIV a=0x80000000 b=0xFFFFFFFF -> result 0x80000000; REMU a=7 b=0 -> result 7; DIVU a=7 b=0 -> result 0xFFFFFFFF.
REQ-038 SHALL test: LT a=-1 b=1 with out_ready held low 5 cycles -> result 1 and cmp_true 1 held stable, in_ready 0 throughout.
REQ-039 SHALL test: rst pulsed in cycle 10 of a DIVU -> out_valid never asserts for it; next request ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM state encoding,
// the WIDTH legality check and op-class helpers.
package alu_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_AND    = 6'd2;
  localparam logic [5:0] OP_XOR    = 6'd3;
  localparam logic [5:0] OP_OR     = 6'd4;
  localparam logic [5:0] OP_SLL    = 6'd5;
  localparam logic [5:0] OP_SRL    = 6'd6;
  localparam logic [5:0] OP_SRA    = 6'd7;
  localparam logic [5:0] OP_EQ     = 6'd8;
  localparam logic [5:0] OP_GEU    = 6'd9;
  localparam logic [5:0] OP_LTU    = 6'd10;
  localparam logic [5:0] OP_NE     = 6'd11;
  localparam logic [5:0] OP_GTU    = 6'd12;
  localparam logic [5:0] OP_LT     = 6'd13;
  localparam logic [5:0] OP_GE     = 6'd14;
  localparam logic [5:0] OP_PASSB  = 6'd63;

  localparam logic [5:0] OP_MUL    = 6'd16;
  localparam logic [5:0] OP_MULH   = 6'd17;
  localparam logic [5:0] OP_MULHSU = 6'd18;
  localparam logic [5:0] OP_MULHU  = 6'd19;
  localparam logic [5:0] OP_DIV    = 6'd20;
  localparam logic [5:0] OP_DIVU   = 6'd21;
  localparam logic [5:0] OP_REM    = 6'd22;
  localparam logic [5:0] OP_REMU   = 6'd23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic bit width_ok(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  // M ops occupy codes 16..23, i.e. op[5:3] == 3'b010.
  function automatic logic is_mop(input logic [5:0] op);
    return op[5:3] == 3'b010;
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Bit-serial multiply (shift-add) and restoring divide on operand magnitudes,
// with the sign correction and divide-by-zero handling applied to the output.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, mc;
  logic               is_div, hi_sel, neg_res, b_zero;

  logic               a_s, b_s, a_neg, b_neg;
  logic [WIDTH-1:0]   ma, mb;
  logic [WIDTH:0]     sum, shifted;
  logic               ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   div_val, div_fix;

  // fn[2] selects divide; for multiply fn[1:0] picks MUL/MULH/MULHSU/MULHU,
  // for divide fn[1] selects remainder and fn[0] selects unsigned.
  always_comb begin
    if (fn[2]) begin
      a_s = !fn[0];
      b_s = !fn[0];
    end else begin
      a_s = (fn[1:0] == 2'd1) || (fn[1:0] == 2'd2);
      b_s = (fn[1:0] == 2'd1);
    end
    a_neg = a_s && a[WIDTH-1];
    b_neg = b_s && b[WIDTH-1];
    ma    = a_neg ? -a : a;
    mb    = b_neg ? -b : b;
  end

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, mc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mc      <= '0;
      is_div  <= 1'b0;
      hi_sel  <= 1'b0;
      neg_res <= 1'b0;
      b_zero  <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      hi     <= '0;
      is_div <= fn[2];
      b_zero <= (b == '0);
      if (fn[2]) begin
        lo      <= ma;
        mc      <= mb;
        hi_sel  <= fn[1];
        neg_res <= fn[1] ? a_neg : (a_neg ^ b_neg);
      end else begin
        lo      <= mb;
        mc      <= ma;
        hi_sel  <= (fn[1:0] != 2'd0);
        neg_res <= a_neg ^ b_neg;
      end
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        hi <= ge ? (shifted[WIDTH-1:0] - mc) : shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], ge};
      end else begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // A zero divisor leaves the dividend magnitude in hi, so the remainder
  // path already yields a; only the quotient needs forcing to all ones.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_res ? -prod : prod;
    div_val  = hi_sel ? hi : lo;
    div_fix  = neg_res ? -div_val : div_val;
    if (is_div)
      result = (b_zero && !hi_sel) ? {WIDTH{1'b1}} : div_fix;
    else
      result = hi_sel ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle base ops, bit-serial M ops, valid/ready on both
// sides. A request moves on a side when valid and ready are both high at a
// rising clock edge; the result holds in DONE until out_ready takes it.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cmp_true,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("alu_iter: WIDTH must be 8, 16, 32 or 64");
    end
  endgenerate

  state_t           state, state_next;
  logic             accept, core_last;
  logic [WIDTH-1:0] core_result, base_res;
  logic             base_cmp;
  logic [SHW-1:0]   sh;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign sh        = b[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_cmp = 1'b0;
    case (op)
      OP_ADD:   base_res = a + b;
      OP_SUB:   base_res = a - b;
      OP_AND:   base_res = a & b;
      OP_XOR:   base_res = a ^ b;
      OP_OR:    base_res = a | b;
      OP_SLL:   base_res = a << sh;
      OP_SRL:   base_res = a >> sh;
      OP_SRA:   base_res = $signed(a) >>> sh;
      OP_EQ:    base_cmp = (a == b);
      OP_GEU:   base_cmp = (a >= b);
      OP_LTU:   base_cmp = (a < b);
      OP_NE:    base_cmp = (a != b);
      OP_GTU:   base_cmp = (a > b);
      OP_LT:    base_cmp = ($signed(a) < $signed(b));
      OP_GE:    base_cmp = ($signed(a) >= $signed(b));
      OP_PASSB: base_res = b;
      default:  base_res = '0;
    endcase
    // Comparison ops leave base_res at zero, so this is the 0/1 zero-extension.
    if (base_cmp)
      base_res = WIDTH'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mop(op) ? S_CALC : S_DONE;
      S_CALC: if (core_last) state_next = S_FIN;
      S_FIN:  state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      result   <= '0;
      cmp_true <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_mop(op)) begin
        result   <= base_res;
        cmp_true <= base_cmp;
      end else if (state == S_FIN) begin
        result   <= core_result;
        cmp_true <= 1'b0;
      end
    end
  end

  alu_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && is_mop(op)),
    .step   (state == S_CALC),
    .fn     (op[2:0]),
    .a      (a),
    .b      (b),
    .last   (core_last),
    .result (core_result)
  );

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter at WIDTH=32: directed vector table, random ops against a
// behavioural model, back-pressure and mid-operation reset sequences.
module tb_alu_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cmp_true;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cmp;
  } vec_t;

  vec_t vecs[$];

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cmp_true  (cmp_true),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [W-1:0]       r;
    logic               c;
    logic               ovf;
    r   = '0;
    c   = 1'b0;
    sp  = '0;
    up  = '0;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      6'd0:  r = x + y;
      6'd1:  r = x - y;
      6'd2:  r = x & y;
      6'd3:  r = x ^ y;
      6'd4:  r = x | y;
      6'd5:  r = x << y[4:0];
      6'd6:  r = x >> y[4:0];
      6'd7:  r = $signed(x) >>> y[4:0];
      6'd8:  c = (x == y);
      6'd9:  c = (x >= y);
      6'd10: c = (x < y);
      6'd11: c = (x != y);
      6'd12: c = (x > y);
      6'd13: c = ($signed(x) < $signed(y));
      6'd14: c = ($signed(x) >= $signed(y));
      6'd63: r = y;
      6'd16: r = x * y;
      6'd17: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        r  = sp[63:32];
      end
      6'd18: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y});
        r  = sp[63:32];
      end
      6'd19: begin
        up = {32'b0, x} * {32'b0, y};
        r  = up[63:32];
      end
      6'd20: r = (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : $signed(x) / $signed(y));
      6'd21: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      6'd22: r = (y == 0) ? x : (ovf ? 32'd0 : $signed(x) % $signed(y));
      6'd23: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    if (c) r = 32'd1;
    return {c, r};
  endfunction

  function automatic int lat_of(input logic [5:0] o);
    return (o >= 6'd16 && o <= 6'd23) ? W + 2 : 1;
  endfunction

  task automatic add_vec(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input logic c);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.cmp = c;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready before send", in_ready, 1);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    // Junk while busy: must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    op = 6'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_result(input string name, input int exp_lat, input int hold);
    int         lat;
    logic [W:0] e;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " out_valid"}, out_valid, 1);
    chk({name, " latency"}, lat, exp_lat);
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard empty"}, 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      chk({name, " held result"}, result, e[W-1:0]);
      chk({name, " held cmp_true"}, cmp_true, e[W]);
      chk({name, " held out_valid"}, out_valid, 1);
      chk({name, " held in_ready"}, in_ready, 0);
      @(negedge clk);
    end
    chk({name, " result"}, result, e[W-1:0]);
    chk({name, " cmp_true"}, cmp_true, e[W]);
    chk({name, " in_ready in DONE"}, in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " out_valid after take"}, out_valid, 0);
    chk({name, " in_ready after take"}, in_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]   ro;
    logic [W-1:0] ra, rb;
    logic [5:0]   op_pool[20];
    int           seen;

    // Vectors with hand-derived expectations.
    add_vec(6'd0,  32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0);
    add_vec(6'd7,  32'h8000_0000, 32'h24,         32'hF800_0000,  1'b0);
    add_vec(6'd17, 32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF,  1'b0);
    add_vec(6'd20, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
    add_vec(6'd23, 32'h7,         32'h0,          32'h7,          1'b0);
    add_vec(6'd21, 32'h7,         32'h0,          32'hFFFF_FFFF,  1'b0);
    add_vec(6'd1,  32'h5,         32'h7,          32'hFFFF_FFFE,  1'b0);
    add_vec(6'd10, 32'h1,         32'h2,          32'h1,          1'b1);
    add_vec(6'd9,  32'h1,         32'h2,          32'h0,          1'b0);
    add_vec(6'd8,  32'h5,         32'h5,          32'h1,          1'b1);
    add_vec(6'd11, 32'h5,         32'h5,          32'h0,          1'b0);
    add_vec(6'd12, 32'hFFFF_FFFF, 32'h1,          32'h1,          1'b1);
    add_vec(6'd14, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0);
    add_vec(6'd5,  32'h1,         32'h21,         32'h2,          1'b0);
    add_vec(6'd6,  32'h8000_0000, 32'h4,          32'h0800_0000,  1'b0);
    add_vec(6'd2,  32'hF0F0,      32'hFF00,       32'hF000,       1'b0);
    add_vec(6'd3,  32'hF0F0,      32'hFF00,       32'h0FF0,       1'b0);
    add_vec(6'd4,  32'hF0F0,      32'hFF00,       32'hFFF0,       1'b0);
    add_vec(6'd63, 32'hDEAD,      32'h1234,       32'h1234,       1'b0);
    add_vec(6'd15, 32'h5,         32'h5,          32'h0,          1'b0);
    add_vec(6'd40, 32'h5,         32'h5,          32'h0,          1'b0);
    add_vec(6'd16, 32'h7,         32'h6,          32'h2A,         1'b0);
    add_vec(6'd16, 32'hFFFF_FFFD, 32'h5,          32'hFFFF_FFF1,  1'b0);
    add_vec(6'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0);
    add_vec(6'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    add_vec(6'd20, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD,  1'b0);
    add_vec(6'd22, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF,  1'b0);
    add_vec(6'd23, 32'h7,         32'h3,          32'h1,          1'b0);
    add_vec(6'd21, 32'd100,       32'd7,          32'hE,          1'b0);
    add_vec(6'd22, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,          1'b0);
    add_vec(6'd20, 32'hFFFF_FFF9, 32'h0,          32'hFFFF_FFFF,  1'b0);
    add_vec(6'd22, 32'hFFFF_FFF9, 32'h0,          32'hFFFF_FFF9,  1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset result", result, 0);
    chk("reset cmp_true", cmp_true, 0);
    chk("reset dbg_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", in_ready, 1);

    // Directed table.
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].cmp, vecs[i].res});
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d op%0d", i, vecs[i].op), lat_of(vecs[i].op), 0);
    end

    // LT with result held under back-pressure.
    exp_q.push_back({1'b1, 32'h1});
    send(6'd13, 32'hFFFF_FFFF, 32'h1);
    wait_result("lt hold", 1, 5);

    // Random ops against the model, with random back-pressure.
    op_pool = '{6'd0, 6'd1, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd13, 6'd14, 6'd63,
                6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd30, 6'd12};
    for (int k = 0; k < 24; k++) begin
      ro = op_pool[$urandom_range(0, 19)];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      exp_q.push_back(model(ro, ra, rb));
      send(ro, ra, rb);
      wait_result($sformatf("rand%0d op%0d", k, ro), lat_of(ro), $urandom_range(0, 2));
    end

    // Reset in cycle 10 of a DIVU: the result must never appear.
    exp_q.push_back(model(6'd21, 32'd100, 32'd7));
    send(6'd21, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort result", result, 0);
    chk("abort cmp_true", cmp_true, 0);
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no result", seen, 0);
    exp_q.push_back({1'b0, 32'd5});
    send(6'd0, 32'd2, 32'd3);
    wait_result("add after abort", 1, 0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
